// File: rtl/mix_output_controller_pkg.sv
// Shared constants for the mix output controller: global layer-state codes,
// default matrix geometry and the controller FSM encoding.
package mix_output_controller_pkg;

  localparam int STATE_LEN = 3;

  localparam logic [STATE_LEN-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_LEN-1:0] ST_EMB  = 3'd1;
  localparam logic [STATE_LEN-1:0] ST_MIX1 = 3'd2;
  localparam logic [STATE_LEN-1:0] ST_MIX2 = 3'd3;
  localparam logic [STATE_LEN-1:0] ST_MIX3 = 3'd4;
  localparam logic [STATE_LEN-1:0] ST_DENS = 3'd5;

  localparam int DEF_HID_DIM = 4;
  localparam int DEF_N_LEN   = 16;

  localparam int MOC_STATE_LEN = 2;

  typedef enum logic [MOC_STATE_LEN-1:0] {
    MOC_IDLE   = 2'd0,
    MOC_FB     = 2'd1,
    MOC_STREAM = 2'd2
  } moc_state_e;

  // A counter over a single row still needs one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mix_out_row_mux.sv
// Picks row i_sel of the flat matrix, or column i_sel when MIX_OUT_TRANSPOSE_EN
// is defined. Purely combinational.
module mix_out_row_mux
  import mix_output_controller_pkg::*;
#(
  parameter int HID_DIM = DEF_HID_DIM,
  parameter int N_LEN   = DEF_N_LEN
) (
  input  logic [HID_DIM*HID_DIM*N_LEN-1:0]  i_mat,
  input  logic [cntWidth(HID_DIM)-1:0]      i_sel,
  output logic [HID_DIM*N_LEN-1:0]          o_row
);

  always_comb begin
    o_row = '0;
    for (int c = 0; c < HID_DIM; c++) begin
`ifdef MIX_OUT_TRANSPOSE_EN
      o_row[c*N_LEN +: N_LEN] = i_mat[(c*HID_DIM + int'(i_sel))*N_LEN +: N_LEN];
`else
      o_row[c*N_LEN +: N_LEN] = i_mat[(int'(i_sel)*HID_DIM + c)*N_LEN +: N_LEN];
`endif
    end
  end

endmodule

// File: rtl/mix_output_controller.sv
// Captures mix-layer results: MIX1/MIX2 go back as feedback, MIX3 is streamed
// row by row to the dense layer. Define MIX_OUT_TRANSPOSE_EN to stream columns.
module mix_output_controller
  import mix_output_controller_pkg::*;
#(
  parameter int HID_DIM = DEF_HID_DIM,
  parameter int N_LEN   = DEF_N_LEN
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [STATE_LEN-1:0]              state,
  input  logic [HID_DIM*HID_DIM*N_LEN-1:0]  d_mix,
  input  logic                              valid_mix,
  output logic [HID_DIM*HID_DIM*N_LEN-1:0]  q_fb,
  output logic                              valid_fb,
  output logic [HID_DIM*N_LEN-1:0]          q_row,
  output logic                              valid_row,
  input  logic                              ready_row,
  output logic                              last_row,
  output logic                              done,
  output logic                              overrun
);

  localparam int MAT_W = HID_DIM*HID_DIM*N_LEN;
  localparam int CNT_W = cntWidth(HID_DIM);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HID_DIM-1);

  moc_state_e        r_state;
  moc_state_e        w_nextState;
  logic [MAT_W-1:0]  r_buf;
  logic [MAT_W-1:0]  r_qFb;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_nextCnt;
  logic              r_done;
  logic              r_overrun;

  logic w_streaming;
  logic w_capFb;
  logic w_capStream;
  logic w_handshake;
  logic w_last;
  logic w_abort;
  logic w_finish;

  // New captures are only taken outside the stream; FB re-captures back-to-back.
  assign w_streaming = (r_state == MOC_STREAM);
  assign w_capFb     = !w_streaming && valid_mix && (state == ST_MIX1 || state == ST_MIX2);
  assign w_capStream = !w_streaming && valid_mix && (state == ST_MIX3);
  assign w_handshake = w_streaming && ready_row;
  assign w_last      = (r_cnt == LAST_CNT);
  assign w_abort     = w_streaming && (state == ST_IDLE);
  assign w_finish    = w_handshake && w_last && !w_abort;

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      MOC_IDLE, MOC_FB: begin
        w_nextState = MOC_IDLE;
        if (w_capFb) begin
          w_nextState = MOC_FB;
        end else if (w_capStream) begin
          w_nextState = MOC_STREAM;
          w_nextCnt   = '0;
        end
      end
      MOC_STREAM: begin
        // An abort beats a simultaneous handshake and suppresses done.
        if (w_abort || w_finish) begin
          w_nextState = MOC_IDLE;
          w_nextCnt   = '0;
        end else if (w_handshake) begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nextState = MOC_IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= MOC_IDLE;
      r_cnt     <= '0;
      r_buf     <= '0;
      r_qFb     <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_done  <= w_finish;
      if (w_capFb || w_capStream) begin
        r_buf <= d_mix;
      end
      if (w_capFb) begin
        r_qFb <= d_mix;
      end
      if (w_streaming && valid_mix) begin
        r_overrun <= 1'b1;
      end
    end
  end

  mix_out_row_mux #(
    .HID_DIM (HID_DIM),
    .N_LEN   (N_LEN)
  ) u_rowMux (
    .i_mat (r_buf),
    .i_sel (r_cnt),
    .o_row (q_row)
  );

  assign q_fb      = r_qFb;
  assign valid_fb  = (r_state == MOC_FB);
  assign valid_row = w_streaming;
  assign last_row  = w_streaming && w_last;
  assign done      = r_done;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_mix_output_controller.sv
// Directed self-checking bench for mix_output_controller (HID_DIM=4, N_LEN=16).
// Row expectations follow MIX_OUT_TRANSPOSE_EN when it is defined.
module tb_mix_output_controller;
  import mix_output_controller_pkg::*;

  localparam int HD    = 4;
  localparam int NL    = 16;
  localparam int MAT_W = HD*HD*NL;
  localparam int ROW_W = HD*NL;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [STATE_LEN-1:0] state;
  logic [MAT_W-1:0]     d_mix;
  logic                 valid_mix;
  logic [MAT_W-1:0]     q_fb;
  logic                 valid_fb;
  logic [ROW_W-1:0]     q_row;
  logic                 valid_row;
  logic                 ready_row;
  logic                 last_row;
  logic                 done;
  logic                 overrun;

  int compared   = 0;
  int mismatched = 0;

  logic [MAT_W-1:0] matA;
  logic [MAT_W-1:0] matF;
  logic             bpPat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  mix_output_controller #(
    .HID_DIM (HD),
    .N_LEN   (NL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .d_mix     (d_mix),
    .valid_mix (valid_mix),
    .q_fb      (q_fb),
    .valid_fb  (valid_fb),
    .q_row     (q_row),
    .valid_row (valid_row),
    .ready_row (ready_row),
    .last_row  (last_row),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [MAT_W-1:0] obs,
                             input logic [MAT_W-1:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Element (r,c) = r*16+c, the hand-chosen pattern that makes row/column order visible.
  function automatic logic [MAT_W-1:0] rampMatrix();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int r = 0; r < HD; r++)
      for (int c = 0; c < HD; c++)
        m[(r*HD + c)*NL +: NL] = NL'(r*16 + c);
    return m;
  endfunction

  function automatic logic [MAT_W-1:0] expRow(input int k);
    logic [MAT_W-1:0] v;
    v = '0;
    for (int c = 0; c < HD; c++) begin
`ifdef MIX_OUT_TRANSPOSE_EN
      v[c*NL +: NL] = NL'(c*16 + k);
`else
      v[c*NL +: NL] = NL'(k*16 + c);
`endif
    end
    return v;
  endfunction

  task automatic applyStimulus(input logic [STATE_LEN-1:0] st, input logic [MAT_W-1:0] m);
    state     = st;
    d_mix     = m;
    valid_mix = 1'b1;
    tick();
    valid_mix = 1'b0;
    d_mix     = matF ^ {MAT_W{1'b1}};
  endtask

  initial begin
    int hs;
    int cyc;
    matA = rampMatrix();
    matF = {(HD*HD){16'hfffc}};

    rst       = 1'b1;
    state     = ST_MIX3;
    d_mix     = matA;
    valid_mix = 1'b1;
    ready_row = 1'b1;
    tick();
    tick();
    checkOutput("rst_qfb", q_fb, '0);
    checkOutput("rst_vfb", valid_fb, 0);
    checkOutput("rst_vrow", valid_row, 0);
    checkOutput("rst_qrow", q_row, '0);
    checkOutput("rst_last", last_row, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ovr", overrun, 0);
    rst       = 1'b0;
    valid_mix = 1'b0;
    state     = ST_IDLE;
    tick();
    checkOutput("post_rst_vrow", valid_row, 0);
    checkOutput("post_rst_vfb", valid_fb, 0);
    checkOutput("post_rst_qfb", q_fb, '0);

    // Ignored capture in a non-mix state.
    applyStimulus(ST_EMB, matA);
    checkOutput("emb_vfb", valid_fb, 0);
    checkOutput("emb_vrow", valid_row, 0);
    checkOutput("emb_qfb", q_fb, '0);

    applyStimulus(ST_MIX1, matA);
    checkOutput("fb1_vfb", valid_fb, 1);
    checkOutput("fb1_qfb", q_fb, matA);
    checkOutput("fb1_vrow", valid_row, 0);
    tick();
    checkOutput("fb1_vfb_drop", valid_fb, 0);
    checkOutput("fb1_qfb_hold", q_fb, matA);

    applyStimulus(ST_MIX2, matF);
    checkOutput("fb2_vfb", valid_fb, 1);
    checkOutput("fb2_qfb", q_fb, matF);
    tick();
    checkOutput("fb2_vfb_drop", valid_fb, 0);

    // Plain stream with the sink always ready.
    ready_row = 1'b1;
    applyStimulus(ST_MIX3, matA);
    checkOutput("s_qfb_kept", q_fb, matF);
    for (int k = 0; k < HD; k++) begin
      checkOutput($sformatf("s_valid%0d", k), valid_row, 1);
      checkOutput($sformatf("s_row%0d", k), q_row, expRow(k));
      checkOutput($sformatf("s_last%0d", k), last_row, (k == HD-1));
      checkOutput($sformatf("s_done%0d", k), done, 0);
      tick();
    end
    checkOutput("s_end_valid", valid_row, 0);
    checkOutput("s_end_done", done, 1);
    tick();
    checkOutput("s_done_drop", done, 0);

    // Backpressure: ready follows 1,0,0,1 and rows must advance only on handshakes.
    ready_row = 1'b0;
    applyStimulus(ST_MIX3, matA);
    hs  = 0;
    cyc = 0;
    while (hs < HD && cyc < 40) begin
      ready_row = bpPat[cyc % 4];
      checkOutput($sformatf("bp_valid_c%0d", cyc), valid_row, 1);
      checkOutput($sformatf("bp_row_c%0d", cyc), q_row, expRow(hs));
      checkOutput($sformatf("bp_last_c%0d", cyc), last_row, (hs == HD-1));
      tick();
      if (ready_row) hs++;
      cyc++;
    end
    checkOutput("bp_no_timeout", (cyc < 40), 1);
    checkOutput("bp_handshakes", hs, HD);
    checkOutput("bp_end_valid", valid_row, 0);
    checkOutput("bp_done", done, 1);

    // Overrun: a capture attempt during row 2 is dropped and latches the flag.
    ready_row = 1'b1;
    applyStimulus(ST_MIX3, matA);
    for (int k = 0; k < HD; k++) begin
      checkOutput($sformatf("ov_row%0d", k), q_row, expRow(k));
      checkOutput($sformatf("ov_flag%0d", k), overrun, (k == 3));
      if (k == 2) begin
        d_mix     = matF;
        valid_mix = 1'b1;
      end
      tick();
      valid_mix = 1'b0;
    end
    checkOutput("ov_done", done, 1);
    checkOutput("ov_sticky", overrun, 1);

    // Abort mid-stream, then confirm the next stream restarts at row 0.
    applyStimulus(ST_MIX3, matA);
    checkOutput("ab_row0", q_row, expRow(0));
    tick();
    checkOutput("ab_row1", q_row, expRow(1));
    state = ST_IDLE;
    tick();
    checkOutput("ab_valid", valid_row, 0);
    checkOutput("ab_done", done, 0);
    tick();
    checkOutput("ab_done_late", done, 0);
    applyStimulus(ST_MIX3, matA);
    checkOutput("ab_restart_row", q_row, expRow(0));
    checkOutput("ab_restart_last", last_row, 0);
    for (int k = 0; k < HD; k++) tick();
    checkOutput("ab_restart_done", done, 1);
    checkOutput("ab_ovr_kept", overrun, 1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("final_rst_ovr", overrun, 0);
    checkOutput("final_rst_qfb", q_fb, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
